// File: rtl/integral_image_builder.sv
// Integral image builder: turns a raster-order 4-bit pixel stream into
// integral-image values and writes them to the classifier buffer. A one-row
// line buffer holds ii(x, y-1), and a running row sum supplies the current row.
module integral_image_builder #(
  parameter int unsigned II_WIDTH  = 160,
  parameter int unsigned II_HEIGHT = 120,
  parameter int unsigned PIX_W     = 4,
  parameter int unsigned DATA_W    = 21,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              buffer_lock,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int unsigned XW = $clog2(II_WIDTH);
  localparam int unsigned YW = $clog2(II_HEIGHT);

  typedef enum logic [1:0] {StIdle, StAccum, StSkip} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [DATA_W-1:0] row_sum_q, row_sum_d;
  logic [DATA_W-1:0] line_buf_q [II_WIDTH];

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              last_q, last_d;
  logic              done_q;
  logic              abort_q, abort_d;

  logic              restart;
  logic              accept;
  logic [XW-1:0]     cur_x;
  logic [YW-1:0]     cur_y;
  logic [DATA_W-1:0] row_sum_new;
  logic [DATA_W-1:0] prev_row;
  logic [DATA_W-1:0] ii;
  logic [ADDR_W-1:0] addr;

  // Next-state: sof handling, pixel acceptance, counters and integral arithmetic
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    row_sum_d   = row_sum_q;
    abort_d     = 1'b0;
    last_d      = 1'b0;
    restart     = 1'b0;
    accept      = 1'b0;
    cur_x       = x_q;
    cur_y       = y_q;

    unique case (state_q)
      StIdle, StSkip: restart = pix_valid & pix_sof;
      StAccum: begin
        restart = pix_valid & pix_sof;
        // A sof anywhere past (0,0) abandons the frame in progress
        abort_d = restart && ((x_q != '0) || (y_q != '0));
        accept  = pix_valid & ~pix_sof;
      end
      default: state_d = StIdle;
    endcase

    // buffer_lock is only looked at here, so mid-frame changes are ignored
    if (restart) begin
      cur_x = '0;
      cur_y = '0;
      x_d   = '0;
      y_d   = '0;
      if (buffer_lock) begin
        state_d = StSkip;
      end else begin
        state_d = StAccum;
        accept  = 1'b1;
      end
    end

    row_sum_new = (cur_x == '0) ? DATA_W'(pix_data) : row_sum_q + DATA_W'(pix_data);
    // Row 0 never reads the line buffer, so it need not be cleared on reset
    prev_row    = (cur_y == '0) ? '0 : line_buf_q[cur_x];
    ii          = row_sum_new + prev_row;
    addr        = ADDR_W'(cur_y) * ADDR_W'(II_WIDTH) + ADDR_W'(cur_x);

    if (accept) begin
      row_sum_d = row_sum_new;
      if (cur_x == XW'(II_WIDTH - 1)) begin
        x_d = '0;
        if (cur_y == YW'(II_HEIGHT - 1)) begin
          y_d     = '0;
          state_d = StIdle;
          last_d  = 1'b1;
        end else begin
          y_d = cur_y + YW'(1);
        end
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end
  end

  // State, counters and registered outputs; frame_done trails the last write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      row_sum_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      row_sum_q <= row_sum_d;
      wr_en_q   <= accept;
      if (accept) begin
        wr_addr_q <= addr;
        wr_data_q <= ii;
      end
      last_q    <= last_d;
      done_q    <= last_q;
      abort_q   <= abort_d;
    end
  end

  // Line buffer: column x holds ii of the previous row until overwritten
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      line_buf_q[cur_x] <= ii;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_integral_image_builder.sv
// Bench for integral_image_builder: a frame-level reference model predicts
// every output cycle by cycle; table-driven frames plus abort/reset sequences.
module tb_integral_image_builder;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic        pix_sof;
  logic [3:0]  pix_data;
  logic        buffer_lock;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [20:0] wr_data;
  logic        frame_done;
  logic        frame_abort;

  always #5 clk = ~clk;

  integral_image_builder dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_data    (pix_data),
    .buffer_lock (buffer_lock),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: frame mode (0 idle, 1 building, 2 locked out), pixel index
  int ref_ii [H][W];
  int seen   [N];
  int m_mode, m_n;
  bit m_last;
  bit e_wr, e_done, e_abort;
  int e_addr, e_data;
  int wr_cnt, done_cnt, abort_cnt, cyc;

  typedef struct {
    string name;
    int    kind;
    int    gap;
    bit    sof;
    bit    lock;
    int    npix;
    int    exp_wr;
    int    exp_done;
    int    exp_last;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pix_of(input int kind, input int n);
    case (kind)
      0:       return 1;
      1:       return 15;
      2:       return ((n % W) + (n / W)) % 16;
      default: return int'($urandom_range(15));
    endcase
  endfunction

  // One cycle: compare outputs against the prediction, then drive and predict
  task automatic step(input bit v, input bit s, input int d, input bit lk, input bit r);
    bit ok;
    bit accept;
    int x, y, val;
    @(negedge clk);
    cyc++;
    checks++;
    ok = (wr_en === e_wr) && (frame_done === e_done) && (frame_abort === e_abort) &&
         (!e_wr || ((wr_addr === e_addr[14:0]) && (wr_data === e_data[20:0])));
    if (!ok) begin
      failures++;
      $display("FAIL cycle %0d: got wr_en=%b addr=%0d data=%0d done=%b abort=%b expected wr_en=%b addr=%0d data=%0d done=%b abort=%b",
               cyc, wr_en, wr_addr, wr_data, frame_done, frame_abort,
               e_wr, e_addr, e_data, e_done, e_abort);
    end
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (int'(wr_addr) < N) seen[wr_addr] = int'(wr_data);
    end
    if (frame_done === 1'b1) done_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;

    rst         = r;
    pix_valid   = v;
    pix_sof     = s;
    pix_data    = 4'(d);
    buffer_lock = lk;

    if (r) begin
      m_mode = 0; m_n = 0; m_last = 1'b0;
      e_wr = 1'b0; e_done = 1'b0; e_abort = 1'b0; e_addr = 0; e_data = 0;
    end else begin
      e_done  = m_last;
      m_last  = 1'b0;
      e_wr    = 1'b0;
      e_abort = 1'b0;
      accept  = 1'b0;
      if (v && s) begin
        if (m_mode == 1 && m_n != 0) e_abort = 1'b1;
        m_n = 0;
        if (lk) m_mode = 2;
        else begin
          m_mode = 1;
          accept = 1'b1;
        end
      end else if (v && m_mode == 1) begin
        accept = 1'b1;
      end
      if (accept) begin
        x   = m_n % W;
        y   = m_n / W;
        val = d + ((y > 0) ? ref_ii[y-1][x] : 0) + ((x > 0) ? ref_ii[y][x-1] : 0)
                - ((x > 0 && y > 0) ? ref_ii[y-1][x-1] : 0);
        ref_ii[y][x] = val;
        e_wr   = 1'b1;
        e_addr = m_n;
        e_data = val;
        m_n++;
        if (m_n == N) begin
          m_n    = 0;
          m_mode = 0;
          m_last = 1'b1;
        end
      end
    end
  endtask

  // Pixels start..start+count-1 of a frame, optional sof on the first, random gaps
  task automatic send_range(input int kind, input int start, input int count,
                            input bit sof_first, input bit lock, input int gap);
    for (int i = 0; i < count; i++) begin
      while (int'($urandom_range(99)) < gap)
        step(1'b0, 1'($urandom_range(1)), int'($urandom_range(15)), 1'($urandom_range(1)), 1'b0);
      step(1'b1, sof_first && (i == 0), pix_of(kind, start + i),
           (i == 0) ? lock : 1'($urandom_range(1)), 1'b0);
    end
  endtask

  task automatic flush();
    repeat (3) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  int w0, d0, a0;

  initial begin
    vecs[0] = '{name: "stray_no_sof", kind: 3, gap: 20, sof: 1'b0, lock: 1'b0, npix: 50,
                exp_wr: 0, exp_done: 0, exp_last: -1};
    vecs[1] = '{name: "locked_frame", kind: 3, gap: 0, sof: 1'b1, lock: 1'b1, npix: 600,
                exp_wr: 0, exp_done: 0, exp_last: -1};
    vecs[2] = '{name: "fifteens_gaps", kind: 1, gap: 20, sof: 1'b1, lock: 1'b0, npix: N,
                exp_wr: N, exp_done: 1, exp_last: 288000};

    rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; buffer_lock = 1'b0;
    m_mode = 0; m_n = 0; m_last = 1'b0;
    e_wr = 1'b0; e_done = 1'b0; e_abort = 1'b0; e_addr = 0; e_data = 0;
    wr_cnt = 0; done_cnt = 0; abort_cnt = 0; cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_wr_addr", int'(wr_addr), 0);
    chk("reset_wr_data", int'(wr_data), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_frame_abort", int'(frame_abort), 0);

    for (int i = 0; i < 3; i++) begin
      w0 = wr_cnt;
      d0 = done_cnt;
      send_range(vecs[i].kind, 0, vecs[i].npix, vecs[i].sof, vecs[i].lock, vecs[i].gap);
      flush();
      chk({vecs[i].name, "_writes"}, wr_cnt - w0, vecs[i].exp_wr);
      chk({vecs[i].name, "_dones"}, done_cnt - d0, vecs[i].exp_done);
      if (vecs[i].exp_last >= 0) chk({vecs[i].name, "_last"}, seen[N-1], vecs[i].exp_last);
    end
    chk("fifteens_addr159", seen[159], 2400);
    chk("fifteens_addr160", seen[160], 30);

    // Ramp frame restarted by sof at (37,5), then completed from the new origin
    w0 = wr_cnt; d0 = done_cnt; a0 = abort_cnt;
    send_range(2, 0, 5 * W + 37, 1'b1, 1'b0, 10);
    step(1'b1, 1'b1, 7, 1'b0, 1'b0);
    send_range(2, 1, N - 1, 1'b0, 1'b0, 0);
    flush();
    chk("abort_pulses", abort_cnt - a0, 1);
    chk("abort_sof_pixel", seen[0], 7);
    chk("abort_dones", done_cnt - d0, 1);
    chk("abort_writes", wr_cnt - w0, 5 * W + 37 + N);

    // Restart under lock: abort pulse, then nothing written
    w0 = wr_cnt; a0 = abort_cnt;
    send_range(3, 0, 100, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 5, 1'b1, 1'b0);
    send_range(3, 0, 50, 1'b0, 1'b0, 0);
    flush();
    chk("lock_abort_pulses", abort_cnt - a0, 1);
    chk("lock_abort_writes", wr_cnt - w0, 100);

    // Reset at (80,60), then a clean all-ones frame
    d0 = done_cnt;
    send_range(3, 0, 60 * W + 80, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 9, 1'b0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("after_rst_wr_en", int'(wr_en), 0);
    chk("after_rst_wr_addr", int'(wr_addr), 0);
    chk("after_rst_wr_data", int'(wr_data), 0);
    flush();
    chk("rst_broken_dones", done_cnt - d0, 0);
    w0 = wr_cnt; d0 = done_cnt;
    send_range(0, 0, N, 1'b1, 1'b0, 0);
    flush();
    chk("ones_writes", wr_cnt - w0, N);
    chk("ones_dones", done_cnt - d0, 1);
    chk("ones_addr0", seen[0], 1);
    chk("ones_addr159", seen[159], 160);
    chk("ones_x4_y3", seen[3 * W + 4], 20);
    chk("ones_last", seen[N-1], 19200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
